// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter (start, 8 data bits LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       wr_uart,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx,
  output logic       txBusy,
  output logic       txErr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             err_q, err_d;
  logic             push;
  logic             pop;
  logic             bit_done;

  assign tx_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign tx_empty = (count_q == '0);
  assign tx       = tx_q;
  assign txBusy   = (state_q != IDLE);
  assign txErr    = err_q;
  assign push     = wr_uart & ~tx_full;
  assign bit_done = (bit_cnt_q == 16'd0);

  // Rejected writes raise the error pulse regardless of a pop in the same cycle.
  always_comb begin
    err_d    = wr_uart & tx_full;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          pop       = 1'b1;
          data_d    = mem_q[rd_ptr_q];
          state_d   = START;
          bit_cnt_d = BIT_RELOAD;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          bit_cnt_d = BIT_RELOAD;
          tx_d      = data_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_d = BIT_RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_d];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d   = STOP;
          bit_cnt_d = BIT_RELOAD;
          tx_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
`endif
      // A queued byte starts its frame straight from the stop bit, no idle gap.
      STOP: begin
        if (bit_done) begin
          if (!tx_empty) begin
            pop       = 1'b1;
            data_d    = mem_q[rd_ptr_q];
            state_d   = START;
            bit_cnt_d = BIT_RELOAD;
            tx_d      = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: written bytes are queued, a serial
// receiver model decodes tx and checks each frame against the queue.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_uart = 1'b0;
  logic [7:0] in = 8'h00;
  logic       tx_full, tx_empty, tx, txBusy, txErr;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] expQ[$];
  int         busyCycles = 0;
  int         busyRises = 0;
  int         errPulses = 0;
  logic       busyPrev = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .wr_uart(wr_uart),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx(tx),
    .txBusy(txBusy), .txErr(txErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One-cycle write; accepted bytes go onto the scoreboard queue.
  task automatic applyStimulus(input logic [7:0] b, input bit expectSent);
    wr_uart = 1'b1;
    in      = b;
    if (expectSent) expQ.push_back(b);
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    while (!(tx_empty === 1'b1 && txBusy === 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, (tx_empty === 1'b1 && txBusy === 1'b0)}, 32'd1);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (txBusy === 1'b1) busyCycles++;
    if (txBusy === 1'b1 && busyPrev !== 1'b1) busyRises++;
    busyPrev = txBusy;
    if (txErr === 1'b1) errPulses++;
  end

  // Serial receiver: samples each bit mid-period after the start edge.
  int         monCnt = 0;
  bit         monActive = 1'b0;
  logic [7:0] monByte = 8'h00;
  logic       parBit = 1'b0;
  logic [7:0] expByte;
  always begin
    int j;
    @(posedge clk);
    #1;
    if (reset !== 1'b1) begin
      monActive = 1'b0;
    end else if (!monActive) begin
      if (tx === 1'b0) begin
        monActive = 1'b1;
        monCnt    = 0;
      end
    end else begin
      monCnt++;
      j = monCnt / CPB;
      if (monCnt % CPB == CPB / 2) begin
        if (j == 0) begin
          checkOutput("start_bit", {31'd0, tx}, 32'd0);
        end else if (j == FRAME_BITS - 1) begin
          checkOutput("stop_bit", {31'd0, tx}, 32'd1);
          monActive = 1'b0;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_frame", {24'd0, monByte}, 32'hFFFF_FFFF);
          end else begin
            expByte = expQ.pop_front();
            checkOutput("rx_byte", {24'd0, monByte}, {24'd0, expByte});
`ifdef UART_TX_PARITY_EN
            checkOutput("parity_bit", {31'd0, parBit}, {31'd0, ^expByte});
`endif
          end
        end else if (j >= 1 && j <= 8) begin
          monByte[j-1] = tx;
        end else begin
          parBit = tx;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] burst [9];
    int b0, r0, e0;
    burst = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9C};

    #2 reset = 1'b0;
    #10;
    checkOutput("reset_state", {27'd0, tx, tx_empty, tx_full, txBusy, txErr}, 32'b11000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("idle_state", {27'd0, tx, tx_empty, tx_full, txBusy, txErr}, 32'b11000);
    end

    $display("[TB] single write 0xA5");
    b0 = busyCycles;
    applyStimulus(8'hA5, 1'b1);
    checkOutput("latency_pre_tx", {31'd0, tx}, 32'd1);
    checkOutput("empty_after_push", {31'd0, tx_empty}, 32'd0);
    @(negedge clk);
    checkOutput("latency_tx_low", {31'd0, tx}, 32'd0);
    checkOutput("busy_at_start", {31'd0, txBusy}, 32'd1);
    checkOutput("empty_after_pop", {31'd0, tx_empty}, 32'd1);
    waitIdle("frame_a5_done", FRAME + 50);
    checkOutput("frame_a5_busy_cycles", busyCycles - b0, FRAME);

    $display("[TB] back-to-back burst of 9 plus overflow");
    b0 = busyCycles;
    r0 = busyRises;
    e0 = errPulses;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(burst[i], 1'b1);
      if (i == 1) begin
        checkOutput("push_pop_same_cycle_empty", {31'd0, tx_empty}, 32'd0);
        checkOutput("push_pop_same_cycle_full", {31'd0, tx_full}, 32'd0);
      end
    end
    checkOutput("full_after_9", {31'd0, tx_full}, 32'd1);
    applyStimulus(8'h11, 1'b0);
    checkOutput("err_pulse", {31'd0, txErr}, 32'd1);
    checkOutput("full_after_reject", {31'd0, tx_full}, 32'd1);
    @(negedge clk);
    checkOutput("err_clear", {31'd0, txErr}, 32'd0);
    waitIdle("burst_done", 9 * FRAME + 100);
    checkOutput("burst_busy_cycles", busyCycles - b0, 9 * FRAME);
    checkOutput("burst_contiguous", busyRises - r0, 1);
    checkOutput("err_pulse_count", errPulses - e0, 1);
    checkOutput("burst_queue_drained", expQ.size(), 0);

    $display("[TB] reset in the middle of frame 0x3C");
    applyStimulus(8'h3C, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    repeat (37) @(negedge clk);
    checkOutput("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_state", {27'd0, tx, tx_empty, tx_full, txBusy, txErr}, 32'b11000);
    @(negedge clk);
    reset = 1'b1;
    b0 = busyCycles;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", {29'd0, tx, tx_empty, txBusy}, 32'b110);
    end
    checkOutput("no_frames_after_reset", busyCycles - b0, 0);

    $display("[TB] write on first edge after reset release");
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(8'hC3, 1'b1);
    checkOutput("push_after_release", {31'd0, tx_empty}, 32'd0);
    @(negedge clk);
    checkOutput("release_frame_start", {31'd0, tx}, 32'd0);
    waitIdle("frame_c3_done", FRAME + 50);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity frames 0x07 and 0x03");
    b0 = busyCycles;
    applyStimulus(8'h07, 1'b1);
    waitIdle("frame_07_done", FRAME + 50);
    checkOutput("frame_07_busy_cycles", busyCycles - b0, 11 * CPB);
    applyStimulus(8'h03, 1'b1);
    waitIdle("frame_03_done", FRAME + 50);
`endif

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal range 4 to 65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of 2, legal range 2 to 64).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in  input  8  byte to transmit.
REQ-006 wr_uart  input  1  write strobe; one byte is offered per cycle while high.
REQ-007 tx_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-008 tx_empty  output  1  FIFO holds 0 entries.
REQ-009 tx  output  1  registered serial line; idle high.
REQ-010 txBusy  output  1  high while a frame is in progress (state not IDLE).
REQ-011 txErr  output  1  one-cycle pulse on a rejected write.

Function
REQ-012 When wr_uart=1 and tx_full=0, SHALL push `in` at that edge; count +1.
REQ-013 When wr_uart=1 and tx_full=1, SHALL drop the byte, leave FIFO unchanged, and assert txErr for exactly the next cycle. This holds even if a pop occurs in the same cycle.
REQ-014 tx_full and tx_empty SHALL decode combinationally from the registered count. Count width SHALL be clog2(FIFO_DEPTH)+1, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 Simultaneous push (not full) and pop SHALL leave count unchanged.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY (only with macro), and STOP.
REQ-017 IDLE with tx_empty=0 SHALL pop the head into the shift register and enter START at the same edge.
REQ-018 START SHALL drive tx=0. DATA SHALL drive 8 bits LSB first. STOP SHALL drive tx=1.
REQ-019 Each state or bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads on each bit.
REQ-020 STOP end with FIFO non-empty SHALL pop and enter START directly, giving zero idle cycles between frames. STOP end with FIFO empty SHALL enter IDLE.
REQ-021 Latency: a byte written at edge k into an empty FIFO with FSM in IDLE SHALL produce tx=0 from edge k+1.
REQ-022 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity). txBusy SHALL be high for that whole span.
REQ-023 IDLE SHALL drive tx=1 continuously.

Reset
REQ-024 On reset low, SHALL immediately (asynchronously) set tx=1, txBusy=0, txErr=0, tx_empty=1, tx_full=0, state IDLE, and clear pointers, count and counters.
REQ-025 Reset mid-frame SHALL abort the frame and discard all FIFO contents. No partial frame resumes after release.
REQ-026 The first push SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: a PARITY state SHALL be inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-028 Macro UART_TX_PARITY_EN undefined: no PARITY state and no parity logic SHALL exist; DATA goes directly to STOP.

Verification
REQ-029 Reset with reset=0, then release -> tx=1, tx_empty=1, tx_full=0, txBusy=0, txErr=0, stable for 100 idle cycles.
REQ-030 Single write 0xA5 (parity off) -> tx=0 from the next edge, then bits 1,0,1,0,0,1,0,1 and stop 1, each 16 cycles; txBusy high for exactly 160 cycles.
REQ-031 Back-to-back writes 0xA5,0x5A,0xFF,0x00,0x12,0x34,0x56,0x78,0x9C -> tx_full=1 after the 9th write. A 10th write (0x11) pulses txErr for 1 cycle and is never transmitted. The 9 frames are contiguous (1440 cycles). Looped into the team's UART receiver, they return the 9 bytes in order.
REQ-032 Reset pulled low 40 cycles into frame 0x3C with 3 bytes queued -> tx=1 immediately, tx_empty=1. After release, tx stays at 1 with no further frames.
REQ-033 With UART_TX_PARITY_EN, write 0x07 -> parity bit 1 and frame of 176 cycles. Write 0x03 -> parity bit 0.
REQ-034 Write while the FSM pops in the same cycle at count=1 -> count stays 1 and tx_empty stays 0.
